// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_pkg
// Purpose  : Opcodes, frame geometry and FSM states shared by the SPI RAM
//            master, slave and bench.
// Revision : 1.0
// ============================================================================
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int WORD_W    = 10;
    localparam int DATA_W    = 8;
    localparam int SHIFT_LEN = 10;
    localparam int RECV_LEN  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_CMD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RECV  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_ram_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_master
// Purpose  : Host-side SPI master for the 10-bit command / 8-bit response
//            RAM slave protocol; SPI bit clock is the system clock.
// Revision : 1.0
// ============================================================================
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int RD_WAIT = 2    // legal range 0..7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [3:0] c_shift_last = 4'(SHIFT_LEN - 1);
    localparam logic [3:0] c_wait_last  = 4'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
    localparam logic [3:0] c_recv_last  = 4'(RECV_LEN - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [WORD_W-1:0]   r_word;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_rx;
    logic                w_accept;
    logic                w_ss_n_next;
    logic                w_mosi_next;
    logic                w_rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are registered from the next state so every pin changes
    // exactly at the edge that enters the corresponding state.
    always_comb begin
        w_accept     = (r_state == ST_IDLE) && cmd_valid && cmd_ready;
        w_state_next = r_state;
        w_ss_n_next  = 1'b1;
        w_mosi_next  = 1'b0;
        w_rd_done    = 1'b0;

        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_START;
            ST_START: w_state_next = ST_CMD;
            ST_CMD:   w_state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == c_shift_last) begin
                    if (r_op != OP_RD_DATA) begin
                        w_state_next = ST_DONE;
                    end else if (RD_WAIT == 0) begin
                        w_state_next = ST_RECV;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT:  if (r_cnt == c_wait_last) w_state_next = ST_RECV;
            ST_RECV:  if (r_cnt == c_recv_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase

        w_ss_n_next = (w_state_next == ST_IDLE) || (w_state_next == ST_DONE);

        // The word only starts shifting once SHIFT is running, so the first
        // SHIFT bit repeats the CMD bit (word[9]).
        case (w_state_next)
            ST_CMD:   w_mosi_next = r_word[WORD_W-1];
            ST_SHIFT: w_mosi_next = (r_state == ST_SHIFT) ? r_word[WORD_W-2]
                                                          : r_word[WORD_W-1];
            default:  w_mosi_next = 1'b0;
        endcase

        w_rd_done = (r_state == ST_RECV) && (w_state_next == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_op      <= OP_WR_ADDR;
            r_rx      <= '0;
        end else begin
            cmd_ready <= (w_state_next == ST_IDLE);
            busy      <= (w_state_next != ST_IDLE);
            SS_n      <= w_ss_n_next;
            MOSI      <= w_mosi_next;
            rd_valid  <= w_rd_done;

            if (w_rd_done) begin
                rd_data <= {r_rx[DATA_W-2:0], MISO};
            end

            if (r_state == ST_RECV) begin
                r_rx <= {r_rx[DATA_W-2:0], MISO};
            end

            // Cleared on entry; terminal count always forces a state change
            // first, so the counter can never wrap.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_SHIFT) || (r_state == ST_WAIT) ||
                         (r_state == ST_RECV)) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_accept) begin
                r_word <= cmd_data;
                r_op   <= cmd_data[WORD_W-1 -: 2];
            end else if (r_state == ST_SHIFT) begin
                r_word <= {r_word[WORD_W-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_master
// Purpose  : Randomised self-checking bench for spi_ram_master, two instances
//            (RD_WAIT=2 and RD_WAIT=0) against a frame-timing reference model.
// Revision : 1.0
// ============================================================================
module tb_spi_ram_master;
    import spi_ram_pkg::*;

    localparam int N_DUT   = 2;
    localparam int Q_DEPTH = 256;
    localparam int ITEM_W  = WORD_W + DATA_W;

    logic                 clk;
    logic                 rst;
    logic [N_DUT-1:0]     cmd_valid;
    logic [N_DUT-1:0]     cmd_ready;
    logic [N_DUT-1:0]     rd_valid;
    logic [N_DUT-1:0]     busy;
    logic [N_DUT-1:0]     ss_n;
    logic [N_DUT-1:0]     mosi;
    logic [N_DUT-1:0]     miso;
    logic [WORD_W-1:0]    cmd_data [N_DUT];
    logic [DATA_W-1:0]    rd_data  [N_DUT];

    spi_ram_master #(.RD_WAIT(2)) u_dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid[0]),
        .cmd_ready (cmd_ready[0]),
        .cmd_data  (cmd_data[0]),
        .rd_valid  (rd_valid[0]),
        .rd_data   (rd_data[0]),
        .busy      (busy[0]),
        .SS_n      (ss_n[0]),
        .MOSI      (mosi[0]),
        .MISO      (miso[0])
    );

    spi_ram_master #(.RD_WAIT(0)) u_dut_w0 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid[1]),
        .cmd_ready (cmd_ready[1]),
        .cmd_data  (cmd_data[1]),
        .rd_valid  (rd_valid[1]),
        .rd_data   (rd_data[1]),
        .busy      (busy[1]),
        .SS_n      (ss_n[1]),
        .MOSI      (mosi[1]),
        .MISO      (miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                 cyc;
    int                 n_tests;
    int                 n_fail;
    bit                 have_frame  [N_DUT];
    int                 frame_t     [N_DUT];
    logic [WORD_W-1:0]  frame_word  [N_DUT];
    logic [DATA_W-1:0]  frame_byte  [N_DUT];
    int                 ready_from  [N_DUT];
    logic [DATA_W-1:0]  exp_rd_data [N_DUT];
    bit                 hold        [N_DUT];
    logic [ITEM_W-1:0]  q_mem       [N_DUT][Q_DEPTH];
    int                 q_head      [N_DUT];
    int                 q_tail      [N_DUT];

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rd_wait(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit is_read(input int i);
        return frame_word[i][WORD_W-1 -: 2] == OP_RD_DATA;
    endfunction

    // Cycles SS_n is held low after the accept cycle.
    function automatic int low_len(input int i);
        return is_read(i) ? (SHIFT_LEN + 2 + rd_wait(i) + RECV_LEN) : (SHIFT_LEN + 2);
    endfunction

    task automatic push_cmd(input int i, input logic [WORD_W-1:0] word,
                            input logic [DATA_W-1:0] b);
        q_mem[i][q_tail[i] % Q_DEPTH] = {word, b};
        q_tail[i]++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            have_frame[i]  = 1'b0;
            frame_t[i]     = 0;
            frame_word[i]  = '0;
            frame_byte[i]  = '0;
            ready_from[i]  = 32'h7fff_ffff;
            exp_rd_data[i] = '0;
        end
    endtask

    task automatic drive_inputs(input int i);
        bit rdy;
        int off;
        int w;
        logic [ITEM_W-1:0] item;
        rdy = !rst && (cyc >= ready_from[i]);
        if (rdy && (q_head[i] != q_tail[i]) && (hold[i] || ($urandom_range(0, 2) == 0))) begin
            item         = q_mem[i][q_head[i] % Q_DEPTH];
            cmd_valid[i] = 1'b1;
            cmd_data[i]  = item[ITEM_W-1 -: WORD_W];
        end else begin
            cmd_valid[i] = rdy ? 1'b0 : 1'($urandom);
            cmd_data[i]  = 10'($urandom);
        end
        off = cyc - frame_t[i];
        w   = rd_wait(i);
        if (have_frame[i] && is_read(i) && (off >= 13 + w) && (off <= 20 + w)) begin
            miso[i] = frame_byte[i][20 + w - off];
        end else begin
            miso[i] = 1'($urandom);
        end
    endtask

    task automatic check_and_update(input int i);
        int   off;
        int   ll;
        bit   in_frame;
        logic exp_ss, exp_mosi, exp_busy, exp_rv, exp_ready;
        logic [ITEM_W-1:0] item;
        off      = cyc - frame_t[i];
        ll       = low_len(i);
        in_frame = have_frame[i] && (off >= 1);
        exp_ss   = !(in_frame && off <= ll);
        exp_busy = in_frame && (off <= ll + 1);
        exp_rv   = in_frame && is_read(i) && (off == ll + 1);
        exp_mosi = 1'b0;
        if (in_frame && off == 2) exp_mosi = frame_word[i][WORD_W-1];
        else if (in_frame && off >= 3 && off <= 12) exp_mosi = frame_word[i][12 - off];
        if (exp_rv) exp_rd_data[i] = frame_byte[i];
        exp_ready = !rst && (cyc >= ready_from[i]);

        check_value($sformatf("ss_n[%0d]", i),      32'(ss_n[i]),      32'(exp_ss));
        check_value($sformatf("mosi[%0d]", i),      32'(mosi[i]),      32'(exp_mosi));
        check_value($sformatf("busy[%0d]", i),      32'(busy[i]),      32'(exp_busy));
        check_value($sformatf("rd_valid[%0d]", i),  32'(rd_valid[i]),  32'(exp_rv));
        check_value($sformatf("rd_data[%0d]", i),   32'(rd_data[i]),   32'(exp_rd_data[i]));
        check_value($sformatf("cmd_ready[%0d]", i), 32'(cmd_ready[i]), 32'(exp_ready));

        if (cmd_valid[i] && exp_ready) begin
            item          = q_mem[i][q_head[i] % Q_DEPTH];
            q_head[i]++;
            have_frame[i] = 1'b1;
            frame_t[i]    = cyc;
            frame_word[i] = item[ITEM_W-1 -: WORD_W];
            frame_byte[i] = item[DATA_W-1:0];
            ready_from[i] = cyc + low_len(i) + 2;
        end
    endtask

    task automatic step_cycle(input bit release_rst, input bit assert_mid);
        @(posedge clk);
        #1;
        cyc++;
        if (release_rst) begin
            rst = 1'b0;
            for (int i = 0; i < N_DUT; i++) ready_from[i] = cyc + 1;
        end
        for (int i = 0; i < N_DUT; i++) drive_inputs(i);
        if (assert_mid) begin
            #2;
            rst = 1'b1;
            model_reset();
            #1;
            for (int i = 0; i < N_DUT; i++) begin
                check_value($sformatf("async_ss_n[%0d]", i),     32'(ss_n[i]),      32'd1);
                check_value($sformatf("async_mosi[%0d]", i),     32'(mosi[i]),      32'd0);
                check_value($sformatf("async_rd_valid[%0d]", i), 32'(rd_valid[i]),  32'd0);
                check_value($sformatf("async_busy[%0d]", i),     32'(busy[i]),      32'd0);
                check_value($sformatf("async_ready[%0d]", i),    32'(cmd_ready[i]), 32'd0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) check_and_update(i);
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N_DUT; i++) begin
            if (q_head[i] != q_tail[i] || cyc < ready_from[i] + 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !all_idle()) begin
            step_cycle(1'b0, 1'b0);
            n++;
        end
        check_value("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic push_random(input int i);
        push_cmd(i, 10'($urandom), 8'($urandom));
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        cmd_valid = '0;
        miso      = '0;
        for (int i = 0; i < N_DUT; i++) begin
            cmd_data[i] = '0;
            q_head[i]   = 0;
            q_tail[i]   = 0;
            hold[i]     = 1'b1;
        end
        model_reset();

        repeat (3) step_cycle(1'b0, 1'b0);
        step_cycle(1'b1, 1'b0);

        // Directed: write address, then read-data returning A5 / 81.
        push_cmd(0, {OP_WR_ADDR, 8'hA5}, 8'h00);
        push_cmd(1, {OP_RD_DATA, 8'h00}, 8'h81);
        drain(200);
        push_cmd(0, {OP_RD_DATA, 8'h00}, 8'hA5);
        push_cmd(1, {OP_WR_DATA, 8'h5A}, 8'h00);
        drain(200);

        // Back-to-back with cmd_valid held.
        for (int i = 0; i < N_DUT; i++) begin
            push_cmd(i, {OP_WR_DATA, 8'hFF}, 8'h00);
            push_cmd(i, {OP_RD_ADDR, 8'h3C}, 8'h00);
            push_cmd(i, {OP_RD_DATA, 8'h00}, 8'($urandom));
        end
        drain(300);

        // Random commands, first with random gaps then held valid.
        for (int i = 0; i < N_DUT; i++) begin
            hold[i] = 1'b0;
            for (int k = 0; k < 25; k++) push_random(i);
        end
        drain(3000);
        for (int i = 0; i < N_DUT; i++) begin
            hold[i] = 1'b1;
            for (int k = 0; k < 25; k++) push_random(i);
        end
        drain(3000);

        // Reset at SHIFT bit 4 of a frame on instance 0.
        push_cmd(0, {OP_WR_DATA, 8'($urandom)}, 8'h00);
        push_cmd(1, {OP_RD_DATA, 8'h00}, 8'($urandom));
        n = 0;
        while (n < 100 && !(have_frame[0] && (cyc - frame_t[0] == 6))) begin
            step_cycle(1'b0, 1'b0);
            n++;
        end
        check_value("mid_reset_reached", 32'(n < 100), 32'd1);
        step_cycle(1'b0, 1'b1);
        step_cycle(1'b0, 1'b0);
        step_cycle(1'b0, 1'b0);
        step_cycle(1'b1, 1'b0);

        for (int i = 0; i < N_DUT; i++) begin
            hold[i] = 1'b0;
            for (int k = 0; k < 10; k++) push_random(i);
        end
        drain(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_ram_master.md
# spi_ram_master

SPI master driving the 10-bit command/response protocol of the single-port-RAM SPI slave, from the host side of the link. It accepts one 10-bit command word per host handshake and serialises it MSB-first onto MOSI under SS_n. For read-data commands it then captures the 8-bit byte returned on MISO and presents it to the host. SPI shift clock is the shared system clock `clk`; no separate SCK is generated.

## Interface
Parameters:
- RD_WAIT, 2: idle SPI cycles between the last MOSI bit of a read-data frame and the first MISO sample; legal range 0–7.

Ports:
- clk  in  1  system clock, also the SPI bit clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host presents a command word
- cmd_ready  out  1  master can accept a command this cycle
- cmd_data  in  10  command word: [9:8] = opcode (00 write addr, 01 write data, 10 read addr, 11 read data), [7:0] = payload
- rd_valid  out  1  one-cycle pulse: rd_data holds a returned byte
- rd_data  out  8  byte captured from MISO
- busy  out  1  high from accept until the frame's DONE cycle inclusive
- SS_n  out  1  slave select, active-low
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

## Operation
- All outputs are registered. Reset values: cmd_ready=0 during reset and 1 in the first IDLE cycle after it; SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, busy=0.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE. The word is latched into a 10-bit shift register on accept. cmd_data is ignored at all other times.
- FSM states:
  - IDLE: SS_n=1, MOSI=0. On accept → START.
  - START: SS_n=0, MOSI=0; 1 cycle → CMD.
  - CMD: SS_n=0, MOSI=word[9]. This is the slave's command-check bit. 1 cycle → SHIFT.
  - SHIFT: SS_n=0, MOSI=word[9] down to word[0], one bit per cycle, 10 cycles. Then → WAIT if opcode==11, else → DONE.
  - WAIT: SS_n=0, MOSI=0, RD_WAIT cycles; skipped when RD_WAIT=0. Then → RECV.
  - RECV: SS_n=0, MOSI=0, 8 cycles. MISO is sampled on each rising edge and shifted into rd_data MSB-first. Then → DONE.
  - DONE: SS_n=1, MOSI=0, 1 cycle. rd_valid=1 in this cycle iff the frame was opcode 11. Then → IDLE.
- A 4-bit bit counter serves SHIFT, WAIT and RECV. It is cleared on every state entry and never wraps past its terminal count.
- Opcodes 00, 01 and 10 never touch rd_data. rd_data holds its last value until the next read-data capture.
- Reset mid-frame: SS_n goes to 1 and MOSI to 0 immediately (asynchronously). The frame is abandoned with no rd_valid. After release the block starts in IDLE.
- The master does not enforce opcode ordering (for example, read-address before read-data). That is host responsibility.

## Timing
- Accept in cycle T: SS_n falls at T+1 (START). CMD bit at T+2. word[9] at T+3 … word[0] at T+12.
- Write and read-address frames: SS_n low for 12 cycles (T+1..T+12). DONE at T+13. Next accept possible at T+14.
- Read-data frame: SS_n low for 12+RD_WAIT+8 cycles. MISO bit 7 is sampled at the end of cycle T+13+RD_WAIT. The rd_valid pulse and the new rd_data appear together at T+21+RD_WAIT.
- Minimum SS_n high time between back-to-back frames: 2 cycles (DONE + IDLE accept).
- cmd_valid held high continuously produces back-to-back frames at this rate. No command is lost or duplicated.

## Structure
- Shared package spi_ram_pkg holds:
  - opcode constants: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11
  - FSM state enum
  - frame constants: WORD_W=10, DATA_W=8, SHIFT_LEN=10, RECV_LEN=8

  The slave and the bench import the same package.
- Single module. The FSM, counter and shift registers are small enough that no sub-module is warranted.

## Test plan
- Reset, then write address: after reset, send 10'b00_1010_0101. Expect SS_n low for exactly 12 cycles, MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1, no rd_valid, busy deasserts after DONE.
- Read data: with RD_WAIT=2, send 10'b11_0000_0000 while the MISO model drives 8'hA5 from the defined sample cycle. Expect rd_data=8'hA5 with a single rd_valid pulse at T+23, and SS_n low for 22 cycles.
- Back-to-back: cmd_valid held high with words 01_FF, 10_3C, 11_00. Expect three frames separated by exactly 2 SS_n-high cycles, opcodes serialised in order, and one rd_valid only.
- Ignored input: cmd_valid asserted with different cmd_data during SHIFT. Expect no accept, the serialised bits unchanged, and the new word taken only once IDLE is reached.
- Reset mid-frame: assert rst at SHIFT bit 4. Expect SS_n=1 and MOSI=0 without waiting for a clock edge, no rd_valid, and cmd_ready=1 in the first cycle after release.
- RD_WAIT=0 boundary: a read-data frame samples MISO starting the cycle right after word[0]. rd_data=8'h81 is captured correctly at T+21.
